// File: rtl/tristate_bus_arbiter_if.sv
// Shared-bus bundle: per-master requests and data in, grant/ownership and the
// tristated data bus out.
interface tristate_bus_arbiter_if #(
  parameter int WIDTH     = 8,
  parameter int N_MASTERS = 4,
  parameter int OW        = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
);
  logic [N_MASTERS-1:0]       req;
  logic [N_MASTERS*WIDTH-1:0] m_data;
  logic [N_MASTERS-1:0]       grant;
  logic                       bus_oe;
  tri   [WIDTH-1:0]           bus;
  logic [OW-1:0]              owner;
  logic                       busy;

  modport master (
    output req, m_data,
    input  grant, bus_oe, bus, owner, busy
  );

  modport slave (
    input  req, m_data,
    output grant, bus_oe, bus, owner, busy
  );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter driving one shared tristate bus from a register, with a
// per-grant hold limit and forced high-Z turnaround between owners.
module tristate_bus_arbiter #(
  parameter int WIDTH      = 8,
  parameter int N_MASTERS  = 4,
  parameter int MAX_HOLD   = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tristate_bus_arbiter_if.slave bus_if
);

  localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic                 oe_q, oe_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [WIDTH-1:0]     drive_q, drive_d;
  logic [OW-1:0]        rr_q, rr_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [TW-1:0]        turn_q, turn_d;

  logic                 any_req;
  logic [OW-1:0]        win;

  // First requester at or above rr_q, wrapping modulo N_MASTERS.
  always_comb begin
    any_req = 1'b0;
    win     = rr_q;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!any_req && bus_if.req[(int'(rr_q) + k) % N_MASTERS]) begin
        any_req = 1'b1;
        win     = OW'((int'(rr_q) + k) % N_MASTERS);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    oe_d    = oe_q;
    owner_d = owner_q;
    drive_d = drive_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = DRIVE;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          owner_d      = win;
          drive_d      = bus_if.m_data[win*WIDTH +: WIDTH];
          oe_d         = 1'b1;
          hold_d       = HW'(1);
        end
      end
      DRIVE: begin
        if (bus_if.req[owner_q] && (hold_q < HW'(MAX_HOLD))) begin
          drive_d = bus_if.m_data[owner_q*WIDTH +: WIDTH];
          hold_d  = hold_q + 1'b1;
        end else begin
          grant_d = '0;
          oe_d    = 1'b0;
          rr_d    = (owner_q == OW'(N_MASTERS - 1)) ? '0 : owner_q + 1'b1;
          hold_d  = '0;
          if (TURNAROUND > 0) begin
            state_d = TURN;
            turn_d  = TW'(TURNAROUND - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      TURN: begin
        if (turn_q == '0) begin
          state_d = IDLE;
        end else begin
          turn_d = turn_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      oe_q    <= 1'b0;
      owner_q <= '0;
      drive_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      oe_q    <= oe_d;
      owner_q <= owner_d;
      drive_q <= drive_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  // oe_q clears asynchronously, so the bus floats the moment reset asserts.
  assign bus_if.bus    = oe_q ? drive_q : {WIDTH{1'bz}};
  assign bus_if.grant  = grant_q;
  assign bus_if.bus_oe = oe_q;
  assign bus_if.owner  = owner_q;
  assign bus_if.busy   = (state_q == DRIVE) || (state_q == TURN);

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scenario bench for tristate_bus_arbiter: hand-derived per-cycle expectations
// are queued as each stimulus cycle is driven and compared after the edge.
module tb_tristate_bus_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  typedef struct packed {
    logic       busy;
    logic       oe;
    logic [3:0] grant;
    logic [1:0] owner;
    logic [7:0] data;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tristate_bus_arbiter_if #(.WIDTH(W), .N_MASTERS(N)) bif ();

  tristate_bus_arbiter #(
    .WIDTH(W), .N_MASTERS(N), .MAX_HOLD(4), .TURNAROUND(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_if(bif.slave)
  );

  int   tests = 0;
  int   fails = 0;
  obs_t exp_q[$];

  // owner and bus are only meaningful while the bus is driven
  function automatic obs_t sample();
    obs_t o;
    o.busy  = bif.busy;
    o.oe    = bif.bus_oe;
    o.grant = bif.grant;
    o.owner = bif.bus_oe ? bif.owner : 2'd0;
    o.data  = bif.bus_oe ? bif.bus : 8'd0;
    return o;
  endfunction

  function automatic obs_t mk(logic b, logic oe, logic [3:0] g, logic [1:0] ow, logic [7:0] d);
    obs_t o;
    o.busy = b; o.oe = oe; o.grant = g; o.owner = ow; o.data = d;
    return o;
  endfunction

  function automatic obs_t idle_o();
    return mk(1'b0, 1'b0, 4'b0000, 2'd0, 8'h00);
  endfunction

  function automatic obs_t turn_o();
    return mk(1'b1, 1'b0, 4'b0000, 2'd0, 8'h00);
  endfunction

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < N; i++) bif.m_data[i*W +: W] = base + 8'(i);
  endtask

  task automatic test_reset();
    obs_t got, want;
    bif.req    = '0;
    bif.m_data = '0;
    #1 rst_n = 1'b0;
    #1;
    got = sample(); want = idle_o(); tests++;
    if (got !== want) begin
      fails++; $display("FAIL reset_assert: got %h want %h", got, want);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(idle_o());
      @(posedge clk); @(negedge clk);
      got = sample(); want = exp_q.pop_front(); tests++;
      if (got !== want) begin
        fails++; $display("FAIL reset_idle cyc %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_single_burst();
    logic [3:0] rq[4];
    obs_t       ex[4];
    obs_t       got, want;
    rq[0] = 4'b0010; ex[0] = mk(1, 1, 4'b0010, 2'd1, 8'hA5);
    rq[1] = 4'b0010; ex[1] = mk(1, 1, 4'b0010, 2'd1, 8'hA5);
    rq[2] = 4'b0000; ex[2] = turn_o();
    rq[3] = 4'b0000; ex[3] = idle_o();
    bif.m_data = 32'h0000_A500;
    for (int i = 0; i < 4; i++) begin
      bif.req = rq[i];
      exp_q.push_back(ex[i]);
      @(posedge clk); @(negedge clk);
      got = sample(); want = exp_q.pop_front(); tests++;
      if (got !== want) begin
        fails++; $display("FAIL single_burst cyc %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_hold_limit();
    obs_t got, want, e;
    set_data(8'h00);
    for (int i = 0; i < 12; i++) begin
      bif.req = (i < 10) ? 4'b0001 : 4'b0000;
      bif.m_data[7:0] = 8'h10 + 8'(i);
      if (i <= 3 || (i >= 6 && i <= 9)) e = mk(1, 1, 4'b0001, 2'd0, 8'h10 + 8'(i));
      else if (i == 4 || i == 10)        e = turn_o();
      else                               e = idle_o();
      exp_q.push_back(e);
      @(posedge clk); @(negedge clk);
      got = sample(); want = exp_q.pop_front(); tests++;
      if (got !== want) begin
        fails++; $display("FAIL hold_limit cyc %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] rq[12];
    obs_t       ex[12];
    obs_t       got, want;
    rst_n = 1'b0;
    bif.req = '0;
    @(negedge clk); rst_n = 1'b1;
    set_data(8'hC0);
    rq[0]  = 4'b1111; ex[0]  = mk(1, 1, 4'b0001, 2'd0, 8'hC0);
    rq[1]  = 4'b1110; ex[1]  = turn_o();
    rq[2]  = 4'b1110; ex[2]  = idle_o();
    rq[3]  = 4'b1110; ex[3]  = mk(1, 1, 4'b0010, 2'd1, 8'hC1);
    rq[4]  = 4'b1100; ex[4]  = turn_o();
    rq[5]  = 4'b1100; ex[5]  = idle_o();
    rq[6]  = 4'b1100; ex[6]  = mk(1, 1, 4'b0100, 2'd2, 8'hC2);
    rq[7]  = 4'b1000; ex[7]  = turn_o();
    rq[8]  = 4'b1000; ex[8]  = idle_o();
    rq[9]  = 4'b1000; ex[9]  = mk(1, 1, 4'b1000, 2'd3, 8'hC3);
    rq[10] = 4'b0000; ex[10] = turn_o();
    rq[11] = 4'b0000; ex[11] = idle_o();
    for (int i = 0; i < 12; i++) begin
      bif.req = rq[i];
      exp_q.push_back(ex[i]);
      @(posedge clk); @(negedge clk);
      got = sample(); want = exp_q.pop_front(); tests++;
      if (got !== want) begin
        fails++; $display("FAIL round_robin cyc %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_wrap_priority();
    logic [3:0] rq[9];
    obs_t       ex[9];
    obs_t       got, want;
    set_data(8'hD0);
    rq[0] = 4'b0100; ex[0] = mk(1, 1, 4'b0100, 2'd2, 8'hD2);
    rq[1] = 4'b1001; ex[1] = turn_o();
    rq[2] = 4'b1001; ex[2] = idle_o();
    rq[3] = 4'b1001; ex[3] = mk(1, 1, 4'b1000, 2'd3, 8'hD3);
    rq[4] = 4'b0001; ex[4] = turn_o();
    rq[5] = 4'b0001; ex[5] = idle_o();
    rq[6] = 4'b0001; ex[6] = mk(1, 1, 4'b0001, 2'd0, 8'hD0);
    rq[7] = 4'b0000; ex[7] = turn_o();
    rq[8] = 4'b0000; ex[8] = idle_o();
    for (int i = 0; i < 9; i++) begin
      bif.req = rq[i];
      exp_q.push_back(ex[i]);
      @(posedge clk); @(negedge clk);
      got = sample(); want = exp_q.pop_front(); tests++;
      if (got !== want) begin
        fails++; $display("FAIL wrap_priority cyc %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] rq[3];
    obs_t       ex[3];
    obs_t       got, want;
    bif.m_data = 32'h003C_005A;
    bif.req    = 4'b0100;
    exp_q.push_back(mk(1, 1, 4'b0100, 2'd2, 8'h3C));
    @(posedge clk); @(negedge clk);
    got = sample(); want = exp_q.pop_front(); tests++;
    if (got !== want) begin
      fails++; $display("FAIL async_pre_drive: got %h want %h", got, want);
    end
    #2 rst_n = 1'b0;
    #1;
    got = sample(); want = idle_o(); tests++;
    if (got !== want) begin
      fails++; $display("FAIL async_release: got %h want %h", got, want);
    end
    bif.req = 4'b0101;
    @(negedge clk);
    got = sample(); want = idle_o(); tests++;
    if (got !== want) begin
      fails++; $display("FAIL async_held: got %h want %h", got, want);
    end
    rst_n = 1'b1;
    rq[0] = 4'b0101; ex[0] = mk(1, 1, 4'b0001, 2'd0, 8'h5A);
    rq[1] = 4'b0000; ex[1] = turn_o();
    rq[2] = 4'b0000; ex[2] = idle_o();
    for (int i = 0; i < 3; i++) begin
      bif.req = rq[i];
      exp_q.push_back(ex[i]);
      @(posedge clk); @(negedge clk);
      got = sample(); want = exp_q.pop_front(); tests++;
      if (got !== want) begin
        fails++; $display("FAIL async_regrant cyc %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_hold_limit();
    test_round_robin();
    test_wrap_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
